// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: pops bytes from a show-ahead FIFO and sends them as 8N1-style UART frames
// (one start bit, DATAW data bits LSB first, one stop bit), back-to-back when data is waiting.
//
// Ports:
//   clk         rising-edge clock
//   rst         synchronous active-high reset
//   i_en        transmit enable; only gates new pops, a running frame always completes
//   o_rd_en     pop strobe to the FIFO read port (combinational)
//   i_rd_data   FIFO head data, valid whenever i_rd_empty=0
//   i_rd_empty  FIFO empty flag
//   o_tx        registered serial line, idle high
//   o_busy      high while a frame is in progress
module fifo_uart_tx #(
  parameter int unsigned DATAW        = 8,
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  output logic             o_rd_en,
  input  logic [DATAW-1:0] i_rd_data,
  input  logic             i_rd_empty,
  output logic             o_tx,
  output logic             o_busy
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam int unsigned IdxW = (DATAW > 1) ? $clog2(DATAW) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(CLKS_PER_BIT - 1);
  localparam logic [IdxW-1:0] IdxLast = IdxW'(DATAW - 1);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  state_e           r_state, w_state_nxt;
  logic [CntW-1:0]  r_cnt, w_cnt_nxt;
  logic [IdxW-1:0]  r_idx, w_idx_nxt;
  logic [DATAW-1:0] r_shift, w_shift_nxt;
  logic             r_tx, w_tx_nxt;

  logic             w_bit_end;
  logic             w_pop;
  logic [DATAW-1:0] w_shift_sh;

  always_comb begin
    w_bit_end   = (r_cnt == '0);
    w_shift_sh  = r_shift >> 1;
    // A pop is only legal from idle or on the final cycle of the stop bit, so the next start
    // bit lines up with the end of the previous frame.
    w_pop       = ~rst & i_en & ~i_rd_empty &
                  ((r_state == StIdle) | ((r_state == StStop) & w_bit_end));

    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_idx_nxt   = r_idx;
    w_shift_nxt = r_shift;
    w_tx_nxt    = r_tx;

    if (r_state != StIdle) begin
      w_cnt_nxt = w_bit_end ? CntLast : r_cnt - CntW'(1);
    end

    unique case (r_state)
      StIdle: begin
        w_tx_nxt = 1'b1;
      end
      StStart: begin
        if (w_bit_end) begin
          w_state_nxt = StData;
          w_idx_nxt   = '0;
          w_tx_nxt    = r_shift[0];
        end
      end
      StData: begin
        if (w_bit_end) begin
          if (r_idx == IdxLast) begin
            w_state_nxt = StStop;
            w_tx_nxt    = 1'b1;
          end else begin
            w_idx_nxt   = r_idx + IdxW'(1);
            w_shift_nxt = w_shift_sh;
            w_tx_nxt    = w_shift_sh[0];
          end
        end
      end
      StStop: begin
        if (w_bit_end) begin
          w_state_nxt = StIdle;
          w_tx_nxt    = 1'b1;
        end
      end
      default: begin
        w_state_nxt = StIdle;
        w_tx_nxt    = 1'b1;
      end
    endcase

    // Capturing on the pop overrides the end-of-stop return to idle.
    if (w_pop) begin
      w_state_nxt = StStart;
      w_shift_nxt = i_rd_data;
      w_cnt_nxt   = CntLast;
      w_idx_nxt   = '0;
      w_tx_nxt    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StIdle;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
      r_shift <= w_shift_nxt;
      r_tx    <= w_tx_nxt;
    end
  end

  assign o_rd_en = w_pop;
  assign o_tx    = r_tx;
  assign o_busy  = (r_state != StIdle);

endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx: self-checking bench for fifo_uart_tx (DATAW=8, CLKS_PER_BIT=4).
// The FIFO is a queue in the bench; the expected line, busy and pop strobe are derived from the
// frame timeline: a pop at cycle p owns cycles p+1..p+40, bit n of the frame occupying 4 cycles.
module tb_fifo_uart_tx;

  localparam int Cpb   = 4;
  localparam int Frame = 10 * Cpb;

  logic       clk;
  logic       rst;
  logic       i_en;
  logic       o_rd_en;
  logic [7:0] i_rd_data;
  logic       i_rd_empty;
  logic       o_tx;
  logic       o_busy;

  fifo_uart_tx #(
    .DATAW        (8),
    .CLKS_PER_BIT (Cpb)
  ) u_dut (
    .clk        (clk),
    .rst        (rst),
    .i_en       (i_en),
    .o_rd_en    (o_rd_en),
    .i_rd_data  (i_rd_data),
    .i_rd_empty (i_rd_empty),
    .o_tx       (o_tx),
    .o_busy     (o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  logic [7:0] fifo[$];
  bit         t_rst, t_en, scramble;
  logic [7:0] scr_val;

  int         cyc = 0;
  int         m_pop_cyc = 0;
  bit         m_active = 0;
  logic [7:0] m_byte = '0;

  logic       e_tx, e_busy, e_rd;
  logic       s_tx, s_busy, s_rd;

  function automatic logic frame_bit(logic [7:0] b, int k);
    int idx;
    idx = (k - 1) / Cpb;
    if (idx == 0) return 1'b0;
    if (idx <= 8) return b[idx-1];
    return 1'b1;
  endfunction

  // Drive one cycle, sample outputs mid-cycle, advance the reference timeline at the edge.
  task automatic step();
    int k;
    k      = cyc - m_pop_cyc;
    e_busy = m_active && k >= 1 && k <= Frame;
    e_tx   = e_busy ? frame_bit(m_byte, k) : 1'b1;
    e_rd   = !t_rst && t_en && fifo.size() != 0 && (!e_busy || k == Frame);
    rst        = t_rst;
    i_en       = t_en;
    i_rd_empty = (fifo.size() == 0);
    if (fifo.size() != 0 && (e_rd || !scramble)) i_rd_data = fifo[0];
    else i_rd_data = scr_val;
    #2;
    s_tx   = o_tx;
    s_busy = o_busy;
    s_rd   = o_rd_en;
    @(posedge clk);
    #1;
    if (t_rst) m_active = 0;
    else if (e_rd) begin
      m_byte    = fifo.pop_front();
      m_active  = 1;
      m_pop_cyc = cyc;
    end else if (e_busy && k == Frame) m_active = 0;
    cyc++;
  endtask

  task automatic test_reset();
    fifo.push_back(8'h5A);
    t_rst = 1; t_en = 1; scramble = 0; scr_val = '0;
    step();
    for (int i = 0; i < 4; i++) begin
      step();
      n_chk++; if (s_tx !== 1'b1) $display("FAIL reset tx cyc=%0d got=%b exp=1", cyc, s_tx); else n_pass++;
      n_chk++; if (s_busy !== 1'b0) $display("FAIL reset busy cyc=%0d got=%b exp=0", cyc, s_busy); else n_pass++;
      n_chk++; if (s_rd !== 1'b0) $display("FAIL reset rd_en cyc=%0d got=%b exp=0", cyc, s_rd); else n_pass++;
    end
    fifo.delete();
    t_rst = 0; t_en = 0;
    step();
  endtask

  task automatic test_single();
    int pops, busy_n;
    pops = 0; busy_n = 0;
    fifo.push_back(8'hA5);
    t_en = 1;
    for (int i = 0; i < 50; i++) begin
      step();
      pops += int'(s_rd); busy_n += int'(s_busy);
      n_chk++; if (s_tx !== e_tx) $display("FAIL single tx cyc=%0d got=%b exp=%b", cyc, s_tx, e_tx); else n_pass++;
      n_chk++; if (s_busy !== e_busy) $display("FAIL single busy cyc=%0d got=%b exp=%b", cyc, s_busy, e_busy); else n_pass++;
      n_chk++; if (s_rd !== e_rd) $display("FAIL single rd_en cyc=%0d got=%b exp=%b", cyc, s_rd, e_rd); else n_pass++;
    end
    n_chk++; if (pops !== 1) $display("FAIL single pop_count got=%0d exp=1", pops); else n_pass++;
    n_chk++; if (busy_n !== 40) $display("FAIL single busy_cycles got=%0d exp=40", busy_n); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int pops, busy_n, p0, p1;
    pops = 0; busy_n = 0; p0 = -1; p1 = -1;
    fifo.push_back(8'h01);
    fifo.push_back(8'hFF);
    t_en = 1;
    for (int i = 0; i < 90; i++) begin
      step();
      if (s_rd === 1'b1) begin
        if (pops == 0) p0 = i; else p1 = i;
        pops++;
      end
      busy_n += int'(s_busy);
      n_chk++; if (s_tx !== e_tx) $display("FAIL b2b tx cyc=%0d got=%b exp=%b", cyc, s_tx, e_tx); else n_pass++;
      n_chk++; if (s_busy !== e_busy) $display("FAIL b2b busy cyc=%0d got=%b exp=%b", cyc, s_busy, e_busy); else n_pass++;
      n_chk++; if (s_rd !== e_rd) $display("FAIL b2b rd_en cyc=%0d got=%b exp=%b", cyc, s_rd, e_rd); else n_pass++;
    end
    n_chk++; if (pops !== 2) $display("FAIL b2b pop_count got=%0d exp=2", pops); else n_pass++;
    n_chk++; if (p1 - p0 !== Frame) $display("FAIL b2b pop_spacing got=%0d exp=%0d", p1 - p0, Frame); else n_pass++;
    n_chk++; if (busy_n !== 80) $display("FAIL b2b busy_cycles got=%0d exp=80", busy_n); else n_pass++;
  endtask

  task automatic test_empty();
    int bad;
    bad = 0;
    t_en = 1;
    for (int i = 0; i < 100; i++) begin
      step();
      if (s_rd !== 1'b0 || s_tx !== 1'b1 || s_busy !== 1'b0) bad++;
    end
    n_chk++; if (bad !== 0) $display("FAIL empty idle_violations got=%0d exp=0", bad); else n_pass++;
  endtask

  task automatic test_enable_drop();
    int pops_off, first;
    pops_off = 0; first = -1;
    fifo.push_back(8'h3C);
    fifo.push_back(8'h11);
    fifo.push_back(8'h22);
    t_en = 1;
    for (int i = 0; i < 200 && !(m_active && cyc - m_pop_cyc == 10); i++) begin
      step();
      n_chk++; if (s_rd !== e_rd) $display("FAIL endrop rd_en cyc=%0d got=%b exp=%b", cyc, s_rd, e_rd); else n_pass++;
    end
    t_en = 0;
    for (int i = 0; i < 60; i++) begin
      step();
      pops_off += int'(s_rd);
      n_chk++; if (s_tx !== e_tx) $display("FAIL endrop tx cyc=%0d got=%b exp=%b", cyc, s_tx, e_tx); else n_pass++;
      n_chk++; if (s_busy !== e_busy) $display("FAIL endrop busy cyc=%0d got=%b exp=%b", cyc, s_busy, e_busy); else n_pass++;
    end
    n_chk++; if (pops_off !== 0) $display("FAIL endrop pops_while_disabled got=%0d exp=0", pops_off); else n_pass++;
    t_en = 1;
    for (int i = 0; i < 100; i++) begin
      step();
      if (s_rd === 1'b1 && first < 0) first = i;
      n_chk++; if (s_tx !== e_tx) $display("FAIL endrop tx2 cyc=%0d got=%b exp=%b", cyc, s_tx, e_tx); else n_pass++;
      n_chk++; if (s_rd !== e_rd) $display("FAIL endrop rd_en2 cyc=%0d got=%b exp=%b", cyc, s_rd, e_rd); else n_pass++;
    end
    n_chk++; if (first < 0 || first > 1) $display("FAIL endrop restart_latency got=%0d exp=0..1", first); else n_pass++;
  endtask

  task automatic test_reset_midframe();
    fifo.push_back(8'h55);
    fifo.push_back(8'hC3);
    t_en = 1;
    for (int i = 0; i < 200 && !(m_active && cyc - m_pop_cyc == 15); i++) step();
    t_rst = 1;
    step();
    t_rst = 0;
    step();
    n_chk++; if (s_tx !== 1'b1) $display("FAIL rstmid tx_after_reset got=%b exp=1", s_tx); else n_pass++;
    n_chk++; if (s_busy !== 1'b0) $display("FAIL rstmid busy_after_reset got=%b exp=0", s_busy); else n_pass++;
    for (int i = 0; i < 60; i++) begin
      step();
      n_chk++; if (s_tx !== e_tx) $display("FAIL rstmid tx cyc=%0d got=%b exp=%b", cyc, s_tx, e_tx); else n_pass++;
      n_chk++; if (s_busy !== e_busy) $display("FAIL rstmid busy cyc=%0d got=%b exp=%b", cyc, s_busy, e_busy); else n_pass++;
      n_chk++; if (s_rd !== e_rd) $display("FAIL rstmid rd_en cyc=%0d got=%b exp=%b", cyc, s_rd, e_rd); else n_pass++;
    end
  endtask

  task automatic test_data_change();
    fifo.push_back(8'h96);
    t_en = 1; scramble = 1; scr_val = 8'h00;
    for (int i = 0; i < 50; i++) begin
      step();
      n_chk++; if (s_tx !== e_tx) $display("FAIL datachg tx cyc=%0d got=%b exp=%b", cyc, s_tx, e_tx); else n_pass++;
    end
    scramble = 0;
  endtask

  task automatic test_random();
    t_en = 1; scramble = 1;
    for (int i = 0; i < 1500; i++) begin
      if (fifo.size() < 4 && $urandom_range(0, 15) == 0) fifo.push_back(8'($urandom));
      t_en    = ($urandom_range(0, 31) != 0);
      t_rst   = ($urandom_range(0, 299) == 0);
      scr_val = 8'($urandom);
      step();
      n_chk++; if (s_tx !== e_tx) $display("FAIL random tx cyc=%0d got=%b exp=%b", cyc, s_tx, e_tx); else n_pass++;
      n_chk++; if (s_busy !== e_busy) $display("FAIL random busy cyc=%0d got=%b exp=%b", cyc, s_busy, e_busy); else n_pass++;
      n_chk++; if (s_rd !== e_rd) $display("FAIL random rd_en cyc=%0d got=%b exp=%b", cyc, s_rd, e_rd); else n_pass++;
    end
    t_rst = 0; scramble = 0;
  endtask

  initial begin
    rst = 1'b1; i_en = 1'b0; i_rd_data = '0; i_rd_empty = 1'b1;
    t_rst = 1; t_en = 0; scramble = 0; scr_val = '0;
    @(posedge clk);
    #1;
    test_reset();
    test_single();
    test_back_to_back();
    test_empty();
    test_enable_drop();
    test_reset_midframe();
    test_data_change();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
